// File: rtl/cu_data_read_engine_control_mc_pkg.sv
// Shared types, constants and helpers for the multi-channel CU data read engine.
package cu_data_read_engine_control_mc_pkg;

    localparam int ARRAY_SIZE_BITS     = 32;
    localparam int CACHELINE_SIZE      = 128;
    localparam int DATA_SIZE_BYTES     = 4;
    localparam int CACHELINE_ARRAY_NUM = CACHELINE_SIZE / DATA_SIZE_BYTES;

    localparam logic [7:0] DATA_READ_CONTROL_ID = 8'h10;
    localparam logic [7:0] DATA_READ_MC_ID_BASE = DATA_READ_CONTROL_ID;

    typedef enum logic [1:0] {
        RMC_IDLE,
        RMC_ACTIVE,
        RMC_DRAIN,
        RMC_DONE
    } read_mc_state;

    typedef enum logic [7:0] {
        CMD_NONE   = 8'h00,
        READ_CL_NA = 8'h0A,
        READ_CL_S  = 8'h50,
        READ_PNA   = 8'h52
    } afu_command_t;

    typedef enum logic [1:0] {CMD_INVALID, CMD_READ, CMD_WRITE} command_type_t;
    typedef enum logic [1:0] {STRUCT_INVALID, READ_DATA, WRITE_DATA} array_struct_t;
    typedef enum logic [2:0] {STRICT, ABORT, PAGE, PREF, SPEC} trans_order_behavior_t;

    typedef struct packed {
        logic [7:0]                 cu_id;
        command_type_t              cmd_type;
        array_struct_t              array_struct;
        logic [ARRAY_SIZE_BITS-1:0] real_size;
        logic [5:0]                 cacheline_offest;
        logic [63:0]                address_offest;
        trans_order_behavior_t      abt;
    } CommandTagLine;

    typedef struct packed {
        logic                  valid;
        afu_command_t          command;
        logic [63:0]           address;
        logic [11:0]           size;
        CommandTagLine         cmd;
        trans_order_behavior_t abt;
    } CommandBufferLine;

    typedef struct packed {
        logic [7:0]                 cu_id;
        command_type_t              cmd_type;
        array_struct_t              array_struct;
        logic [ARRAY_SIZE_BITS-1:0] real_size;
    } ResponseTagLine;

    typedef struct packed {
        logic           valid;
        ResponseTagLine cmd;
    } ResponseBufferLine;

    typedef struct packed {
        logic alfull;
    } BufferStatus;

    typedef struct packed {
        logic [63:0]                base;
        logic [ARRAY_SIZE_BITS-1:0] remaining;
        logic [63:0]                offset;
    } ReadStreamDescriptor;

    function automatic trans_order_behavior_t map_CABT(input logic [2:0] cfg);
        case (cfg)
            3'd1:    return ABORT;
            3'd2:    return PAGE;
            3'd3:    return PREF;
            3'd4:    return SPEC;
            default: return STRICT;
        endcase
    endfunction

    // Byte size of a partial read; anything covering a full line is a whole line.
    function automatic logic [11:0] cmd_size_calculate(input logic [ARRAY_SIZE_BITS-1:0] remaining);
        if (remaining >= ARRAY_SIZE_BITS'(CACHELINE_ARRAY_NUM)) return 12'h080;
        return 12'(remaining * ARRAY_SIZE_BITS'(DATA_SIZE_BYTES));
    endfunction

endpackage

// File: rtl/cu_data_read_engine_control_mc_if.sv
// Read command / response / buffer status bundle between the engine and the command buffer.
interface cu_data_read_engine_control_mc_if
    import cu_data_read_engine_control_mc_pkg::*;
();
    BufferStatus       read_command_buffer_status;
    ResponseBufferLine read_response;
    CommandBufferLine  read_command;

    modport master (
        input  read_command_buffer_status,
        input  read_response,
        output read_command
    );

    modport slave (
        output read_command_buffer_status,
        output read_response,
        input  read_command
    );
endinterface

// File: rtl/cu_data_read_engine_control_mc_rr_arbiter_n.sv
// Round-robin arbiter: search starts one past the last grant; pointer moves only on a grant.
module cu_data_read_engine_control_mc_rr_arbiter_n #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clock,
    input  logic          rst,
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          grant_valid_o
);
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] cand;

    always_comb begin
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        cand          = '0;
        for (int i = 0; i < N; i++) begin
            cand = ptr_q + IW'(i);
            if (!grant_valid_o && req_i[cand]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = cand;
                grant_o[cand] = 1'b1;
            end
        end
        ptr_d = ptr_q;
        if (grant_valid_o) begin
            ptr_d = (grant_idx_o == IW'(N - 1)) ? '0 : grant_idx_o + IW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
endmodule

// File: rtl/cu_data_read_engine_control_mc.sv
// Multi-channel read engine: per-stream cacheline reads issued round-robin under credit limits.
//   state      | meaning
//   RMC_IDLE   | waiting for a start pulse
//   RMC_ACTIVE | elements left to request
//   RMC_DRAIN  | all requested, waiting for outstanding responses
//   RMC_DONE   | one-cycle completion pulse
module cu_data_read_engine_control_mc
    import cu_data_read_engine_control_mc_pkg::*;
#(
    parameter int         NUM_CHANNELS            = 4,
    parameter int         MAX_OUTSTANDING         = 32,
    parameter int         MAX_OUTSTANDING_CH      = 16,
    parameter logic [7:0] CU_READ_CONTROL_ID_BASE = DATA_READ_MC_ID_BASE
) (
    input  logic                                           clock,
    input  logic                                           rst,
    input  logic                                           enabled_i,
    input  logic [63:0]                                    cu_configure_i,
    input  logic [NUM_CHANNELS-1:0]                        stream_start_i,
    input  logic [NUM_CHANNELS-1:0][63:0]                  stream_base_i,
    input  logic [NUM_CHANNELS-1:0][ARRAY_SIZE_BITS-1:0]   stream_size_i,
    cu_data_read_engine_control_mc_if.master               cmd_if,
    output logic [NUM_CHANNELS-1:0]                        stream_busy_o,
    output logic [NUM_CHANNELS-1:0]                        stream_done_o,
    output logic [NUM_CHANNELS-1:0][ARRAY_SIZE_BITS-1:0]   read_job_counter_done_o,
    output logic                                           resp_error_o
);
    localparam int IW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int CH_W  = $clog2(MAX_OUTSTANDING_CH + 1);

    localparam logic [ARRAY_SIZE_BITS-1:0] CL_NUM_L  = ARRAY_SIZE_BITS'(CACHELINE_ARRAY_NUM);
    localparam logic [CH_W-1:0]            MAX_CH_L  = CH_W'(MAX_OUTSTANDING_CH);
    localparam logic [OUT_W-1:0]           MAX_GLB_L = OUT_W'(MAX_OUTSTANDING);

    read_mc_state               state_q    [NUM_CHANNELS];
    read_mc_state               state_d    [NUM_CHANNELS];
    ReadStreamDescriptor        desc_q     [NUM_CHANNELS];
    ReadStreamDescriptor        desc_d     [NUM_CHANNELS];
    logic [CH_W-1:0]            ch_out_q   [NUM_CHANNELS];
    logic [CH_W-1:0]            ch_out_d   [NUM_CHANNELS];
    logic [ARRAY_SIZE_BITS-1:0] done_cnt_q [NUM_CHANNELS];
    logic [ARRAY_SIZE_BITS-1:0] done_cnt_d [NUM_CHANNELS];

    logic [OUT_W-1:0]  glb_out_q, glb_out_d;
    CommandBufferLine  cmd_q, cmd_d;
    ResponseBufferLine resp_q;
    logic [3:0]        cfg_q;
    logic              err_q, err_d;

    logic [NUM_CHANNELS-1:0] req, gnt, ret;
    logic [IW-1:0]           gnt_idx;
    logic                    gnt_valid;

    logic [ARRAY_SIZE_BITS-1:0] g_rem, g_real;
    logic                       g_last;

    logic [7:0]    resp_rel;
    logic [IW-1:0] resp_ch;
    logic          resp_hit;

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            req[c] = (state_q[c] == RMC_ACTIVE) && (desc_q[c].remaining != '0) &&
                     (ch_out_q[c] < MAX_CH_L) && (glb_out_q < MAX_GLB_L) &&
                     !cmd_if.read_command_buffer_status.alfull && enabled_i;
        end
    end

    cu_data_read_engine_control_mc_rr_arbiter_n #(.N(NUM_CHANNELS)) u_arb (
        .clock         (clock),
        .rst           (rst),
        .req_i         (req),
        .grant_o       (gnt),
        .grant_idx_o   (gnt_idx),
        .grant_valid_o (gnt_valid)
    );

    // A response retires only if it maps to a channel that actually has reads in flight.
    always_comb begin
        resp_rel = resp_q.cmd.cu_id - CU_READ_CONTROL_ID_BASE;
        resp_ch  = resp_rel[IW-1:0];
        resp_hit = resp_q.valid && (resp_q.cmd.cmd_type == CMD_READ) &&
                   (resp_q.cmd.array_struct == READ_DATA) &&
                   (resp_rel < 8'(NUM_CHANNELS)) && (ch_out_q[resp_ch] != '0);
        ret = '0;
        if (resp_hit) ret[resp_ch] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        desc_d     = desc_q;
        ch_out_d   = ch_out_q;
        done_cnt_d = done_cnt_q;
        glb_out_d  = glb_out_q;
        err_d      = err_q;
        cmd_d      = '0;

        g_rem  = desc_q[gnt_idx].remaining;
        g_last = (g_rem <= CL_NUM_L);
        g_real = g_last ? g_rem : CL_NUM_L;

        if (gnt_valid) begin
            cmd_d.valid = 1'b1;
            if (cfg_q[3]) begin
                cmd_d.command = READ_CL_S;
                cmd_d.size    = 12'h080;
            end else begin
                cmd_d.command = g_last ? READ_PNA : READ_CL_NA;
                cmd_d.size    = cmd_size_calculate(g_rem);
            end
            cmd_d.address              = desc_q[gnt_idx].base + desc_q[gnt_idx].offset;
            cmd_d.cmd.cu_id            = CU_READ_CONTROL_ID_BASE + 8'(gnt_idx);
            cmd_d.cmd.cmd_type         = CMD_READ;
            cmd_d.cmd.array_struct     = READ_DATA;
            cmd_d.cmd.real_size        = g_real;
            cmd_d.cmd.cacheline_offest = '0;
            cmd_d.cmd.address_offest   = desc_q[gnt_idx].offset;
            cmd_d.cmd.abt              = map_CABT(cfg_q[2:0]);
            cmd_d.abt                  = map_CABT(cfg_q[2:0]);
        end

        for (int c = 0; c < NUM_CHANNELS; c++) begin
            case (state_q[c])
                RMC_IDLE: begin
                    if (stream_start_i[c]) begin
                        desc_d[c].base      = stream_base_i[c];
                        desc_d[c].remaining = stream_size_i[c];
                        desc_d[c].offset    = '0;
                        ch_out_d[c]         = '0;
                        done_cnt_d[c]       = '0;
                        state_d[c] = (stream_size_i[c] == '0) ? RMC_DONE : RMC_ACTIVE;
                    end
                end
                RMC_ACTIVE: begin
                    if (gnt[c]) begin
                        desc_d[c].remaining = g_last ? '0 : g_rem - CL_NUM_L;
                        desc_d[c].offset    = desc_q[c].offset + 64'(CACHELINE_SIZE);
                        if (g_last) state_d[c] = RMC_DRAIN;
                    end
                end
                RMC_DRAIN: begin
                    if (ch_out_q[c] == '0) state_d[c] = RMC_DONE;
                end
                RMC_DONE: state_d[c] = RMC_IDLE;
                default:  state_d[c] = RMC_IDLE;
            endcase

            if (gnt[c] && !ret[c])      ch_out_d[c] = ch_out_q[c] + CH_W'(1);
            else if (!gnt[c] && ret[c]) ch_out_d[c] = ch_out_q[c] - CH_W'(1);
            if (ret[c]) done_cnt_d[c] = done_cnt_q[c] + resp_q.cmd.real_size;
        end

        if (gnt_valid && !resp_hit)      glb_out_d = glb_out_q + OUT_W'(1);
        else if (!gnt_valid && resp_hit) glb_out_d = glb_out_q - OUT_W'(1);

        if (resp_q.valid && !resp_hit) err_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c]    <= RMC_IDLE;
                desc_q[c]     <= '0;
                ch_out_q[c]   <= '0;
                done_cnt_q[c] <= '0;
            end
            glb_out_q <= '0;
            cmd_q     <= '0;
            resp_q    <= '0;
            cfg_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            desc_q     <= desc_d;
            ch_out_q   <= ch_out_d;
            done_cnt_q <= done_cnt_d;
            glb_out_q  <= glb_out_d;
            cmd_q      <= cmd_d;
            resp_q     <= cmd_if.read_response;
            err_q      <= err_d;
            if (cu_configure_i != '0) cfg_q <= cu_configure_i[3:0];
        end
    end

    assign cmd_if.read_command = cmd_q;
    assign resp_error_o        = err_q;

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            stream_busy_o[c]           = (state_q[c] != RMC_IDLE);
            stream_done_o[c]           = (state_q[c] == RMC_DONE);
            read_job_counter_done_o[c] = done_cnt_q[c];
        end
    end
endmodule

// File: tb/tb_cu_data_read_engine_control_mc.sv
// Directed bench for the multi-channel read engine: vector table plus corner-case sequences.
module tb_cu_data_read_engine_control_mc;
    import cu_data_read_engine_control_mc_pkg::*;

    localparam int         NCH  = 4;
    localparam logic [7:0] BASE = DATA_READ_MC_ID_BASE;

    logic clock = 1'b0;
    logic rst = 1'b1;
    logic enabled = 1'b0;
    logic [63:0] cfg = '0;
    logic [NCH-1:0] start = '0;
    logic [NCH-1:0][63:0] sbase = '0;
    logic [NCH-1:0][ARRAY_SIZE_BITS-1:0] ssize = '0;
    logic [NCH-1:0] busy, done;
    logic [NCH-1:0][ARRAY_SIZE_BITS-1:0] jobcnt;
    logic err;

    cu_data_read_engine_control_mc_if bus_if();

    cu_data_read_engine_control_mc #(
        .NUM_CHANNELS(NCH), .MAX_OUTSTANDING(32), .MAX_OUTSTANDING_CH(16),
        .CU_READ_CONTROL_ID_BASE(BASE)
    ) dut (
        .clock                   (clock),
        .rst                     (rst),
        .enabled_i               (enabled),
        .cu_configure_i          (cfg),
        .stream_start_i          (start),
        .stream_base_i           (sbase),
        .stream_size_i           (ssize),
        .cmd_if                  (bus_if),
        .stream_busy_o           (busy),
        .stream_done_o           (done),
        .read_job_counter_done_o (jobcnt),
        .resp_error_o            (err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    CommandBufferLine  cmds[$];
    ResponseBufferLine pend[$];
    bit auto_resp = 1'b0;
    int done_pulses[NCH];

    typedef struct {
        int          ch;
        logic [63:0] base;
        int          size;
        int          exp_ncmd;
        int          exp_last_real;
        logic [11:0] exp_last_size;
        int          exp_count;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic ResponseBufferLine to_resp(input CommandBufferLine c);
        ResponseBufferLine r;
        r = '0;
        r.valid            = 1'b1;
        r.cmd.cu_id        = c.cmd.cu_id;
        r.cmd.cmd_type     = c.cmd.cmd_type;
        r.cmd.array_struct = c.cmd.array_struct;
        r.cmd.real_size    = c.cmd.real_size;
        return r;
    endfunction

    function automatic ResponseBufferLine mk_resp(input logic [7:0] id, input int sz);
        ResponseBufferLine r;
        r = '0;
        r.valid            = 1'b1;
        r.cmd.cu_id        = id;
        r.cmd.cmd_type     = CMD_READ;
        r.cmd.array_struct = READ_DATA;
        r.cmd.real_size    = ARRAY_SIZE_BITS'(sz);
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        for (int c = 0; c < NCH; c++) if (done[c]) done_pulses[c]++;
        if (bus_if.read_command.valid) begin
            cmds.push_back(bus_if.read_command);
            if (auto_resp) pend.push_back(to_resp(bus_if.read_command));
        end
        if (pend.size() > 0) bus_if.read_response = pend.pop_front();
        else                 bus_if.read_response = '0;
    endtask

    task automatic clear_obs();
        cmds.delete();
        for (int c = 0; c < NCH; c++) done_pulses[c] = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        pend.delete();
        bus_if.read_response = '0;
        clear_obs();
    endtask

    task automatic start_ch(input int c, input logic [63:0] b, input int sz);
        sbase[c] = b;
        ssize[c] = ARRAY_SIZE_BITS'(sz);
        start[c] = 1'b1;
        tick();
        start = '0;
    endtask

    task automatic wait_done(input int c, input int budget);
        int n;
        n = 0;
        while (done_pulses[c] == 0 && n < budget) begin
            tick();
            n++;
        end
        if (done_pulses[c] == 0) begin
            checks++;
            errors++;
            $display("FAIL timeout_ch%0d: no done pulse within %0d cycles", c, budget);
        end
        tick();
        tick();
    endtask

    initial begin
        bus_if.read_command_buffer_status = '0;
        bus_if.read_response = '0;
        for (int c = 0; c < NCH; c++) done_pulses[c] = 0;

        vecs[0] = '{0, 64'h1000,  96, 3, 32, 12'h080,  96};
        vecs[1] = '{1, 64'h2000,  33, 2,  1, 12'h004,  33};
        vecs[2] = '{2, 64'h3000,   5, 1,  5, 12'h014,   5};
        vecs[3] = '{3, 64'h4000,  32, 1, 32, 12'h080,  32};
        vecs[4] = '{0, 64'h5000,  64, 2, 32, 12'h080,  64};

        // reset state
        do_reset();
        enabled = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_cmd_valid", bus_if.read_command.valid, 0);
        check("rst_jobcnt", jobcnt, 0);

        // all four channels together: grants rotate 0,1,2,3,0,1,2,3
        auto_resp = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            sbase[c] = 64'h10000 * (c + 1);
            ssize[c] = 64;
        end
        start = '1;
        tick();
        start = '0;
        for (int n = 0; n < 100; n++) begin
            if (done_pulses[0] > 0 && done_pulses[1] > 0 && done_pulses[2] > 0 && done_pulses[3] > 0) break;
            tick();
        end
        tick();
        check("rr_ncmd", cmds.size(), 8);
        for (int k = 0; k < cmds.size() && k < 8; k++) begin
            check($sformatf("rr_cuid_%0d", k), cmds[k].cmd.cu_id, BASE + 8'(k % 4));
            check($sformatf("rr_addr_%0d", k), cmds[k].address, 64'h10000 * ((k % 4) + 1) + 64'(128 * (k / 4)));
        end
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("rr_pulses_%0d", c), done_pulses[c], 1);
            check($sformatf("rr_count_%0d", c), jobcnt[c], 64);
        end

        // table-driven single-stream vectors, responses returned immediately
        for (int v = 0; v < 5; v++) begin
            clear_obs();
            start_ch(vecs[v].ch, vecs[v].base, vecs[v].size);
            wait_done(vecs[v].ch, 200);
            check($sformatf("v%0d_ncmd", v), cmds.size(), vecs[v].exp_ncmd);
            for (int k = 0; k < cmds.size(); k++) begin
                check($sformatf("v%0d_addr_%0d", v, k), cmds[k].address, vecs[v].base + 64'(128 * k));
                check($sformatf("v%0d_aoff_%0d", v, k), cmds[k].cmd.address_offest, 64'(128 * k));
                check($sformatf("v%0d_cuid_%0d", v, k), cmds[k].cmd.cu_id, BASE + 8'(vecs[v].ch));
                if (k == cmds.size() - 1) begin
                    check($sformatf("v%0d_lastcmd", v), cmds[k].command, READ_PNA);
                    check($sformatf("v%0d_lastreal", v), cmds[k].cmd.real_size, vecs[v].exp_last_real);
                    check($sformatf("v%0d_lastsize", v), cmds[k].size, vecs[v].exp_last_size);
                end else begin
                    check($sformatf("v%0d_cmd_%0d", v, k), cmds[k].command, READ_CL_NA);
                    check($sformatf("v%0d_real_%0d", v, k), cmds[k].cmd.real_size, 32);
                    check($sformatf("v%0d_size_%0d", v, k), cmds[k].size, 12'h080);
                end
            end
            check($sformatf("v%0d_count", v), jobcnt[vecs[v].ch], vecs[v].exp_count);
            check($sformatf("v%0d_pulses", v), done_pulses[vecs[v].ch], 1);
            check($sformatf("v%0d_busy", v), busy[vecs[v].ch], 0);
        end
        check("table_err", err, 0);

        // per-channel credit limit with responses withheld; first command latency
        auto_resp = 1'b0;
        clear_obs();
        start_ch(0, 64'h20000, 32 * 20);
        check("lat_none_yet", cmds.size(), 0);
        tick();
        check("lat_first", cmds.size(), 1);
        for (int n = 0; n < 30; n++) tick();
        check("credit_stall", cmds.size(), 16);
        pend.push_back(to_resp(cmds[0]));
        for (int n = 0; n < 10; n++) tick();
        check("credit_one_more", cmds.size(), 17);
        check("credit_addr17", cmds[cmds.size()-1].address, 64'h20000 + 64'(128 * 16));
        check("credit_count", jobcnt[0], 32);
        do_reset();

        // alfull held mid-stream
        auto_resp = 1'b1;
        start_ch(1, 64'h30000, 32 * 12);
        tick();
        tick();
        tick();
        bus_if.read_command_buffer_status.alfull = 1'b1;
        tick();
        begin
            int n_hold;
            n_hold = cmds.size();
            for (int n = 0; n < 5; n++) tick();
            check("alfull_hold", cmds.size(), n_hold);
        end
        bus_if.read_command_buffer_status.alfull = 1'b0;
        wait_done(1, 200);
        check("alfull_ncmd", cmds.size(), 12);
        for (int k = 0; k < cmds.size(); k++)
            check($sformatf("alfull_addr_%0d", k), cmds[k].address, 64'h30000 + 64'(128 * k));
        check("alfull_count", jobcnt[1], 384);

        // start on a busy channel is ignored
        clear_obs();
        start_ch(2, 64'h6000, 64);
        start_ch(2, 64'h9000, 32);
        wait_done(2, 200);
        check("busy_ign_ncmd", cmds.size(), 2);
        check("busy_ign_addr0", cmds[0].address, 64'h6000);
        check("busy_ign_addr1", cmds[1].address, 64'h6080);
        check("busy_ign_count", jobcnt[2], 64);
        check("busy_ign_pulses", done_pulses[2], 1);

        // zero-size start: immediate completion, counter cleared
        clear_obs();
        start_ch(3, 64'h7000, 0);
        check("zero_busy", busy[3], 1);
        tick();
        check("zero_pulse", done_pulses[3], 1);
        tick();
        tick();
        check("zero_pulse_width", done_pulses[3], 1);
        check("zero_count", jobcnt[3], 0);
        check("zero_ncmd", cmds.size(), 0);
        check("zero_idle", busy[3], 0);

        // unexpected responses
        check("pre_err", err, 0);
        pend.push_back(mk_resp(BASE + 8'(NCH), 7));
        tick();
        tick();
        tick();
        check("err_range", err, 1);
        check("err_range_cnt2", jobcnt[2], 64);
        check("err_range_cnt1", jobcnt[1], 384);
        do_reset();
        check("err_cleared", err, 0);
        pend.push_back(mk_resp(BASE + 8'd1, 5));
        tick();
        tick();
        tick();
        check("err_idle", err, 1);
        check("err_idle_cnt1", jobcnt[1], 0);

        // reset mid-stream, then a stray response for the discarded stream
        do_reset();
        auto_resp = 1'b0;
        start_ch(0, 64'h8000, 320);
        for (int n = 0; n < 5; n++) tick();
        check("mid_busy", busy[0], 1);
        rst = 1'b1;
        tick();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_cmd", bus_if.read_command == '0, 1);
        check("mid_rst_jobcnt", jobcnt, 0);
        check("mid_rst_err", err, 0);
        rst = 1'b0;
        tick();
        pend.push_back(to_resp(cmds[0]));
        tick();
        tick();
        tick();
        check("mid_stray_err", err, 1);
        check("mid_stray_cnt", jobcnt[0], 0);

        // READ_CL_S selected with abt mapping
        do_reset();
        cfg = 64'h9;
        tick();
        cfg = '0;
        auto_resp = 1'b1;
        start_ch(1, 64'hA000, 33);
        wait_done(1, 200);
        check("cls_ncmd", cmds.size(), 2);
        for (int k = 0; k < cmds.size(); k++) begin
            check($sformatf("cls_cmd_%0d", k), cmds[k].command, READ_CL_S);
            check($sformatf("cls_size_%0d", k), cmds[k].size, 12'h080);
            check($sformatf("cls_abt_%0d", k), cmds[k].abt, ABORT);
            check($sformatf("cls_tagabt_%0d", k), cmds[k].cmd.abt, ABORT);
            check($sformatf("cls_type_%0d", k), cmds[k].cmd.cmd_type, CMD_READ);
        end
        if (cmds.size() == 2) begin
            check("cls_real0", cmds[0].cmd.real_size, 32);
            check("cls_real1", cmds[1].cmd.real_size, 1);
        end
        check("cls_count", jobcnt[1], 33);
        check("final_err", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
